fp_multiply_pipe: RTL and testbench
===================================

// Module: fp_multiply_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready flow control.
//  Default format is binary32. Latency is fixed at 3 cycles. Exception flags accompany each result.
//  Used as the multiply stage of neuron MAC datapaths; sits between operand fetch and the accumulator.
// PARAMETERS
//  EXP_W   8   exponent field width (bits); bias = 2**(EXP_W-1)-1
//  MAN_W   23  stored mantissa (fraction) width (bits); word width W = 1+EXP_W+MAN_W
// PORTS
//  clk_i       in   1   clock, rising edge
//  reset_ni    in   1   asynchronous active-low reset
//  valid_i     in   1   operand pair a_i/b_i valid
//  ready_o     out  1   block can accept operands this cycle
//  a_i         in   W   operand A {sign, exp, frac}
//  b_i         in   W   operand B
//  valid_o     out  1   product_o/flags_o valid
//  ready_i     in   1   downstream accepts result this cycle
//  product_o   out  W   rounded product
//  flags_o     out  4   {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  Reset: all stage valid bits, valid_o, product_o and flags_o go to 0 immediately and stay 0 until reset_ni releases.
//   Reset mid-operation discards in-flight data; no partial result is emitted.
//  Pipeline: S1 unpack/classify, sign XOR, exponent sum (EXP_W+2-bit signed);
//   S2 (MAN_W+1)x(MAN_W+1) significand multiply; S3 normalise, round, pack, flag.
//  Handshake: advance = !valid_o | ready_i; ready_o = advance.
//   Input transfer: valid_i & ready_o. Output transfer: valid_o & ready_i.
//   When advance = 0 the whole pipeline holds. No data loss or duplication; outputs stay stable while stalled.
//   Bubbles propagate as invalid stages; throughput is 1 result/cycle with ready_i held high.
//  Latency: an input accepted at edge N gives valid_o at edge N+3 when there are no stalls.
//  Denormals: inputs with exp=0 are treated as signed zero (flush-to-zero).
//   Tiny results are flushed to signed zero with underflow=1 and inexact=1.
//  Rounding: round-to-nearest, ties-to-even, using guard and sticky bits over the full product.
//   A mantissa carry-out from rounding increments the exponent.
//  Normalisation: product significand in [1,4); if >=2, shift right 1 and increment exponent.
//  Overflow: biased exponent >= 2**EXP_W-1 after rounding -> signed infinity; overflow=1, inexact=1.
//  Underflow: biased exponent <= 0 -> signed zero, underflow=1.
//  Specials (checked in S1 and override arithmetic):
//   NaN on either input -> canonical qNaN {0, all-ones exp, 1, zeros}; invalid=0 for qNaN, invalid=1 for sNaN.
//   inf x 0 -> canonical qNaN, invalid=1.
//   inf x finite-nonzero -> signed infinity, no flags.
//   zero x finite -> zero with sign = sa^sb, no flags.
//  Exact results: inexact=0. Flags are per-result, not sticky.
// TESTING (EXP_W=8, MAN_W=23)
//  40200000 x 40800000 -> 41200000, flags 0, valid_o exactly 3 cycles after accept
//  C0400000 x 40E00000 -> C1A80000; 00000000 x BF800000 -> 80000000;
//   3FC00000 x 3FC00000 -> 40100000
//  3F800001 x 3F800001 -> 3F800002, inexact=1;
//   7F000000 x 7F000000 -> 7F800000, overflow=1, inexact=1
//  00800000 x 00800000 -> 00000000, underflow=1;
//   7F800000 x 00000000 -> 7FC00000, invalid=1;
//   7F800001 x 3F800000 -> 7FC00000, invalid=1
//  Back-to-back stream of 8 random pairs with ready_i=1 -> 8 results in order on consecutive cycles,
//   each bit-exact against a reference model
//  ready_i low for 5 cycles with valid_i high -> ready_o low while valid_o high; outputs held stable;
//   no results lost or duplicated after release
//  reset_ni pulsed low with 2 ops in flight -> valid_o=0 immediately; the next accepted op emerges after 3 cycles

Source files
------------

// File: rtl/fp_multiply_pipe.sv
// -----------------------------------------------------------------------------
// fp_multiply_pipe
//   Pipelined IEEE-754-style floating-point multiplier (binary32 by default)
//   with valid/ready flow control and per-result exception flags. It is the
//   multiply stage of the neuron MAC datapath, between operand fetch and the
//   accumulator.
//
//   Pipeline ranks (each with its own valid bit):
//     s0  input capture of the accepted operand pair
//     s1  unpack/classify, special-case resolution, sign XOR, exponent sum
//     s2  (MAN_W+1)x(MAN_W+1) significand multiply
//     out normalise, round-to-nearest-even, pack, flag (product_o/flags_o)
//   An operand pair accepted at clock edge N is presented on valid_o after
//   edge N+3 when nothing stalls.
//
//   Denormal inputs are flushed to signed zero. Tiny results are flushed to
//   signed zero with underflow and inexact set.
//
// Ports
//   clk_i      in   1  clock, rising edge
//   reset_ni   in   1  asynchronous active-low reset
//   valid_i    in   1  a_i/b_i hold a valid operand pair
//   ready_o    out  1  block accepts operands this cycle
//   a_i, b_i   in   W  operands {sign, exp, frac}, W = 1+EXP_W+MAN_W
//   valid_o    out  1  product_o/flags_o valid
//   ready_i    in   1  downstream accepts the result this cycle
//   product_o  out  W  rounded product
//   flags_o    out  4  {invalid, overflow, underflow, inexact}
// -----------------------------------------------------------------------------
module fp_multiply_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [EXP_W+MAN_W:0] product_o,
  output logic [3:0]           flags_o
);

  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int SW      = MAN_W + 1;          // significand incl. hidden bit
  localparam int PW      = 2 * SW;             // full product width
  localparam int EW      = EXP_W + 2;          // signed working exponent
  localparam int BIAS    = 2**(EXP_W-1) - 1;
  localparam int EXP_MAX = 2**EXP_W - 1;

  localparam logic signed [EW-1:0] EXP_MAX_S = EW'(EXP_MAX);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic zero;   // exp == 0 (denormals flushed to zero)
    logic inf;
    logic nan;
    logic snan;   // NaN with quiet bit clear
  } class_t;

  function automatic class_t classify(input logic [W-1:0] x);
    class_t c;
    logic   exp_ones;
    logic   frac_nz;
    exp_ones = &x[W-2 -: EXP_W];
    frac_nz  = |x[MAN_W-1:0];
    c.zero   = ~|x[W-2 -: EXP_W];
    c.inf    = exp_ones & ~frac_nz;
    c.nan    = exp_ones & frac_nz;
    c.snan   = exp_ones & frac_nz & ~x[MAN_W-1];
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Flow control. advance = !valid_o | ready_i is the single enable for every
  // rank: when it is low the whole pipeline holds (outputs stay stable), when
  // it is high every rank shifts, bubbles included. ready_o equals advance, so
  // an input transfer is valid_i & ready_o and an output transfer is
  // valid_o & ready_i; nothing is dropped or duplicated.
  // ---------------------------------------------------------------------------
  logic advance;
  assign advance = !valid_o || ready_i;
  assign ready_o = advance;

  // s0: captured operands
  logic         s0_valid;
  logic [W-1:0] s0_a;
  logic [W-1:0] s0_b;

  // s1: classified operands
  logic                 s1_valid;
  logic                 s1_sign;
  logic signed [EW-1:0] s1_exp_sum;
  logic [SW-1:0]        s1_sig_a;
  logic [SW-1:0]        s1_sig_b;
  logic                 s1_special;
  logic [W-1:0]         s1_spec_word;
  logic [3:0]           s1_spec_flags;

  // s2: raw product
  logic                 s2_valid;
  logic                 s2_sign;
  logic signed [EW-1:0] s2_exp_sum;
  logic [PW-1:0]        s2_prod;
  logic                 s2_special;
  logic [W-1:0]         s2_spec_word;
  logic [3:0]           s2_spec_flags;

  // ---------------------------------------------------------------------------
  // s1 combinational: classification and special-case resolution. Specials
  // are decided here and carried alongside the arithmetic, overriding it at
  // the output rank.
  // ---------------------------------------------------------------------------
  class_t               a_cls;
  class_t               b_cls;
  logic                 c1_sign;
  logic signed [EW-1:0] c1_exp_sum;
  logic                 c1_special;
  logic [W-1:0]         c1_spec_word;
  logic [3:0]           c1_spec_flags;

  always_comb begin
    a_cls         = classify(s0_a);
    b_cls         = classify(s0_b);
    c1_sign       = s0_a[W-1] ^ s0_b[W-1];
    // Unbiased-sum-plus-bias fits in EXP_W+2 signed bits for every finite pair.
    c1_exp_sum    = EW'(s0_a[W-2 -: EXP_W]) + EW'(s0_b[W-2 -: EXP_W]) - EW'(BIAS);
    c1_special    = 1'b0;
    c1_spec_word  = '0;
    c1_spec_flags = 4'b0000;
    if (a_cls.nan || b_cls.nan) begin
      c1_special    = 1'b1;
      c1_spec_word  = QNAN;
      c1_spec_flags = {a_cls.snan | b_cls.snan, 3'b000};
    end else if ((a_cls.inf && b_cls.zero) || (b_cls.inf && a_cls.zero)) begin
      c1_special    = 1'b1;
      c1_spec_word  = QNAN;
      c1_spec_flags = 4'b1000;
    end else if (a_cls.inf || b_cls.inf) begin
      c1_special    = 1'b1;
      c1_spec_word  = {c1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_cls.zero || b_cls.zero) begin
      c1_special    = 1'b1;
      c1_spec_word  = {c1_sign, {(W-1){1'b0}}};
    end
  end

  // ---------------------------------------------------------------------------
  // Output rank combinational: normalise, round, detect range exceptions.
  // The product of two [1,2) significands lies in [1,4); the top bit tells
  // whether a one-place right shift (and exponent increment) is needed.
  // ---------------------------------------------------------------------------
  logic                 c3_top;
  logic [MAN_W-1:0]     c3_frac;
  logic                 c3_guard;
  logic                 c3_sticky;
  logic                 c3_round_up;
  logic [SW-1:0]        c3_frac_r;
  logic                 c3_carry;
  logic signed [EW-1:0] c3_exp;
  logic                 c3_overflow;
  logic                 c3_underflow;
  logic                 c3_inexact;
  logic [W-1:0]         c3_word;
  logic [3:0]           c3_flags;

  always_comb begin
    c3_top = s2_prod[PW-1];
    if (c3_top) begin
      c3_frac   = s2_prod[PW-2 -: MAN_W];
      c3_guard  = s2_prod[PW-2-MAN_W];
      c3_sticky = |s2_prod[PW-3-MAN_W:0];
    end else begin
      c3_frac   = s2_prod[PW-3 -: MAN_W];
      c3_guard  = s2_prod[PW-3-MAN_W];
      c3_sticky = |s2_prod[PW-4-MAN_W:0];
    end
    c3_inexact  = c3_guard | c3_sticky;
    // Ties-to-even: round up on guard unless it is an exact tie with an even LSB.
    c3_round_up = c3_guard & (c3_sticky | c3_frac[0]);
    c3_frac_r   = {1'b0, c3_frac} + SW'(c3_round_up);
    // A carry out of rounding leaves the fraction all zeros; only the
    // exponent needs bumping.
    c3_carry    = c3_frac_r[MAN_W];
    c3_exp      = s2_exp_sum + EW'(c3_top) + EW'(c3_carry);

    c3_overflow  = !c3_exp[EW-1] && (c3_exp >= EXP_MAX_S);
    c3_underflow = c3_exp[EW-1] || (c3_exp == '0);

    c3_word  = {s2_sign, c3_exp[EXP_W-1:0], c3_frac_r[MAN_W-1:0]};
    c3_flags = {3'b000, c3_inexact};
    if (s2_special) begin
      c3_word  = s2_spec_word;
      c3_flags = s2_spec_flags;
    end else if (c3_overflow) begin
      c3_word  = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      c3_flags = 4'b0101;
    end else if (c3_underflow) begin
      c3_word  = {s2_sign, {(W-1){1'b0}}};
      c3_flags = 4'b0011;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers. Data registers load on every advance; only the
  // output rank is gated by its incoming valid so a bubble never disturbs
  // the last presented result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s0_valid      <= 1'b0;
      s0_a          <= '0;
      s0_b          <= '0;
      s1_valid      <= 1'b0;
      s1_sign       <= 1'b0;
      s1_exp_sum    <= '0;
      s1_sig_a      <= '0;
      s1_sig_b      <= '0;
      s1_special    <= 1'b0;
      s1_spec_word  <= '0;
      s1_spec_flags <= 4'b0000;
      s2_valid      <= 1'b0;
      s2_sign       <= 1'b0;
      s2_exp_sum    <= '0;
      s2_prod       <= '0;
      s2_special    <= 1'b0;
      s2_spec_word  <= '0;
      s2_spec_flags <= 4'b0000;
      valid_o       <= 1'b0;
      product_o     <= '0;
      flags_o       <= 4'b0000;
    end else if (advance) begin
      s0_valid      <= valid_i;
      s0_a          <= a_i;
      s0_b          <= b_i;

      s1_valid      <= s0_valid;
      s1_sign       <= c1_sign;
      s1_exp_sum    <= c1_exp_sum;
      s1_sig_a      <= {1'b1, s0_a[MAN_W-1:0]};
      s1_sig_b      <= {1'b1, s0_b[MAN_W-1:0]};
      s1_special    <= c1_special;
      s1_spec_word  <= c1_spec_word;
      s1_spec_flags <= c1_spec_flags;

      s2_valid      <= s1_valid;
      s2_sign       <= s1_sign;
      s2_exp_sum    <= s1_exp_sum;
      s2_prod       <= PW'(s1_sig_a) * PW'(s1_sig_b);
      s2_special    <= s1_special;
      s2_spec_word  <= s1_spec_word;
      s2_spec_flags <= s1_spec_flags;

      valid_o       <= s2_valid;
      if (s2_valid) begin
        product_o   <= c3_word;
        flags_o     <= c3_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_multiply_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_multiply_pipe
//   Self-checking bench for fp_multiply_pipe (binary32). Expected results come
//   from a plain-arithmetic reference model of IEEE multiply with FTZ and
//   round-to-nearest-even. Scenario tasks run in sequence from one initial
//   block and compare observed results inline.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp_multiply_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 32;
  localparam int NDIR  = 15;

  // ---------------- clock / reset ----------------
  logic         clk_i    = 1'b0;
  logic         reset_ni = 1'b0;
  logic         valid_i  = 1'b0;
  logic         ready_i  = 1'b0;
  logic [W-1:0] a_i      = '0;
  logic [W-1:0] b_i      = '0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] product_o;
  logic [3:0]   flags_o;

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  fp_multiply_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .product_o (product_o),
    .flags_o   (flags_o)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [35:0] exp_q[$];      // {flags, product} per accepted operand pair
  logic [35:0] got_q[$];      // {flags, product} per output transfer
  int          got_cyc_q[$];  // edge count at which each transferred result was observed

  always @(negedge clk_i) begin
    if (reset_ni && valid_o && ready_i) begin
      got_q.push_back({flags_o, product_o});
      got_cyc_q.push_back(cyc);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int                ea, eb, e, sh;
    longint unsigned   ma, mb, p, q, rem, half;
    logic              s, inexact;
    logic              a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic [35:0]       r;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_snan = a_nan && !a[22];
    b_snan = b_nan && !b[22];
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) r = {a_snan || b_snan, 3'b000, 32'h7FC00000};
    else if ((a_inf && b_zero) || (b_inf && a_zero)) r = {4'b1000, 32'h7FC00000};
    else if (a_inf || b_inf) r = {4'b0000, s, 8'hFF, 23'd0};
    else if (a_zero || b_zero) r = {4'b0000, s, 31'd0};
    else begin
      ma = 64'h800000 + longint'(a[22:0]);
      mb = 64'h800000 + longint'(b[22:0]);
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e  = e + 1;
      end else begin
        sh = 23;
      end
      q       = p >> sh;
      rem     = p - (q << sh);
      half    = 64'd1 << (sh - 1);
      inexact = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= 255)    r = {4'b0101, s, 8'hFF, 23'd0};
      else if (e <= 0) r = {4'b0011, s, 31'd0};
      else             r = {3'b000, inexact, s, e[7:0], q[22:0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0:       r[30:23] = 8'h00;
      1:       begin r[30:23] = 8'hFF; r[22:0] = '0; end
      2:       begin r[30:23] = 8'hFF; if (r[22:0] == 0) r[0] = 1'b1; end
      3, 4:    r[30:23] = 8'($urandom_range(1, 254));
      5:       begin r[30:23] = 8'($urandom_range(110, 144)); r[15:0] = '0; end
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    int guard;
    guard   = 0;
    valid_i = 1'b1;
    a_i     = a;
    b_i     = b;
    @(negedge clk_i);
    while (!ready_o && guard < 200) begin
      guard++;
      @(negedge clk_i);
    end
    if (!ready_o) begin
      total++;
      bad++;
      $display("FAIL send_timeout: ready_o=%0b after %0d cycles, required 1", ready_o, guard);
    end
    @(posedge clk_i);
    #1;
    acc     = cyc;
    valid_i = 1'b0;
    exp_q.push_back(ref_mul(a, b));
  endtask

  task automatic wait_results(input int n, input string tag);
    int guard;
    guard = 0;
    while (got_q.size() < n && guard < 100) begin
      @(posedge clk_i);
      #1;
      guard++;
    end
    if (got_q.size() < n) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d results, required %0d", tag, got_q.size(), n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic compare_streams(input string tag);
    int n;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_count: got %0d results, required %0d", tag, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s_data[%0d]: got flags=%h product=%h, required flags=%h product=%h",
                 tag, i, got_q[i][35:32], got_q[i][31:0], exp_q[i][35:32], exp_q[i][31:0]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_ni = 1'b0;
    ready_i  = 1'b0;
    idle(3);
    @(negedge clk_i);
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", valid_o); end
    total++;
    if (product_o !== 32'h0) begin bad++; $display("FAIL reset_product: got %h, required 00000000", product_o); end
    total++;
    if (flags_o !== 4'h0) begin bad++; $display("FAIL reset_flags: got %h, required 0", flags_o); end
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b, required 1", ready_o); end
    reset_ni = 1'b1;
    idle(2);
  endtask

  localparam logic [31:0] VA [NDIR] = '{
    32'h40200000, 32'hC0400000, 32'h00000000, 32'h3FC00000, 32'h3F800001,
    32'h7F000000, 32'h00800000, 32'h7F800000, 32'h7F800001, 32'h7FC00000,
    32'hFF800000, 32'h00400000, 32'h3F800001, 32'h3F800003, 32'h80000000};
  localparam logic [31:0] VB [NDIR] = '{
    32'h40800000, 32'h40E00000, 32'hBF800000, 32'h3FC00000, 32'h3F800001,
    32'h7F000000, 32'h00800000, 32'h00000000, 32'h3F800000, 32'h3F800000,
    32'h40000000, 32'h3F800000, 32'h3FC00000, 32'h3FC00000, 32'hFF800000};
  localparam logic [31:0] VP [NDIR] = '{
    32'h41200000, 32'hC1A80000, 32'h80000000, 32'h40100000, 32'h3F800002,
    32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
    32'hFF800000, 32'h00000000, 32'h3FC00002, 32'h3FC00004, 32'h7FC00000};
  localparam logic [3:0] VF [NDIR] = '{
    4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
    4'h5, 4'h3, 4'h8, 4'h8, 4'h0,
    4'h0, 4'h0, 4'h1, 4'h1, 4'h8};

  task automatic test_directed();
    int acc;
    ready_i = 1'b1;
    for (int i = 0; i < NDIR; i++) begin
      clear_sb();
      send(VA[i], VB[i], acc);
      wait_results(1, "directed");
      if (got_q.size() >= 1) begin
        total++;
        if (got_q[0][31:0] !== VP[i]) begin
          bad++;
          $display("FAIL directed_product[%0d] %h x %h: got %h, required %h",
                   i, VA[i], VB[i], got_q[0][31:0], VP[i]);
        end
        total++;
        if (got_q[0][35:32] !== VF[i]) begin
          bad++;
          $display("FAIL directed_flags[%0d] %h x %h: got %h, required %h",
                   i, VA[i], VB[i], got_q[0][35:32], VF[i]);
        end
        total++;
        if (got_cyc_q[0] - acc != 3) begin
          bad++;
          $display("FAIL directed_latency[%0d]: got %0d cycles, required 3", i, got_cyc_q[0] - acc);
        end
      end
      idle(4);
      total++;
      if (got_q.size() != 1) begin
        bad++;
        $display("FAIL directed_count[%0d]: got %0d results, required 1", i, got_q.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    clear_sb();
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) send(rand_op(), rand_op(), acc);
    wait_results(8, "b2b");
    idle(4);
    compare_streams("b2b");
    for (int i = 1; i < got_cyc_q.size(); i++) begin
      total++;
      if (got_cyc_q[i] - got_cyc_q[i-1] != 1) begin
        bad++;
        $display("FAIL b2b_spacing[%0d]: got gap %0d cycles, required 1", i, got_cyc_q[i] - got_cyc_q[i-1]);
      end
    end
  endtask

  task automatic test_stall();
    clear_sb();
    ready_i = 1'b0;
    fork
      begin
        int acc;
        for (int i = 0; i < 6; i++) send(rand_op(), rand_op(), acc);
      end
      begin
        int          g;
        logic [35:0] hold;
        g = 0;
        @(negedge clk_i);
        while (!valid_o && g < 50) begin
          @(negedge clk_i);
          g++;
        end
        total++;
        if (valid_o !== 1'b1) begin bad++; $display("FAIL stall_fill: valid_o=%b, required 1", valid_o); end
        hold = {flags_o, product_o};
        for (int k = 0; k < 5; k++) begin
          @(negedge clk_i);
          total++;
          if (ready_o !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b, required 0", k, ready_o); end
          total++;
          if (valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b, required 1", k, valid_o); end
          total++;
          if ({flags_o, product_o} !== hold) begin
            bad++;
            $display("FAIL stall_hold[%0d]: got %h, required %h", k, {flags_o, product_o}, hold);
          end
        end
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
      end
    join
    wait_results(6, "stall");
    idle(6);
    compare_streams("stall");
  endtask

  task automatic test_reset_mid();
    int acc;
    clear_sb();
    ready_i = 1'b0;
    send(rand_op(), rand_op(), acc);
    send(rand_op(), rand_op(), acc);
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if (valid_o !== 1'b1) begin bad++; $display("FAIL rmid_before: valid_o=%b, required 1", valid_o); end
    #2;
    reset_ni = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b, required 0", valid_o); end
    total++;
    if (product_o !== 32'h0) begin bad++; $display("FAIL rmid_product: got %h, required 00000000", product_o); end
    total++;
    if (flags_o !== 4'h0) begin bad++; $display("FAIL rmid_flags: got %h, required 0", flags_o); end
    @(negedge clk_i);
    reset_ni = 1'b1;
    clear_sb();
    idle(1);
    ready_i = 1'b1;
    send(32'h40200000, 32'h40800000, acc);
    wait_results(1, "rmid");
    idle(6);
    compare_streams("rmid");
    if (got_cyc_q.size() >= 1) begin
      total++;
      if (got_cyc_q[0] - acc != 3) begin
        bad++;
        $display("FAIL rmid_latency: got %0d cycles, required 3", got_cyc_q[0] - acc);
      end
    end
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    clear_sb();
    fork
      begin
        int acc;
        for (int i = 0; i < 150; i++) begin
          idle($urandom_range(0, 2));
          send(rand_op(), rand_op(), acc);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk_i);
          #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join
    wait_results(150, "random");
    idle(6);
    compare_streams("random");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
